// File: rtl/excess3_pkg.sv
// Shared constants and FSM state type for the serial Excess-3 to BCD converter.
package excess3_pkg;

  localparam logic [3:0] E3_MIN   = 4'd3;
  localparam logic [3:0] E3_MAX   = 4'd12;
  localparam logic [3:0] E3_BIAS  = 4'd3;
  localparam logic [3:0] BCD_BAD  = 4'hF;
  localparam logic [1:0] LAST_BIT = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/e3_digit_decode.sv
// Combinational lookup from a 4-bit Excess-3 code to a BCD digit plus illegal-code flag.
module e3_digit_decode
  import excess3_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    bcd_o = BCD_BAD;
    err_o = 1'b1;
    if (code_i >= E3_MIN && code_i <= E3_MAX) begin
      bcd_o = code_i - E3_BIAS;
      err_o = 1'b0;
    end
  end

endmodule

// File: rtl/excess3_to_bcd_serial.sv
// Serial Excess-3 digit receiver with a one-entry ready/valid BCD output stage.
// Define EXCESS3_ERR_COUNT_EN to add the saturating illegal-digit counter output err_cnt.
module excess3_to_bcd_serial
  import excess3_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclr,
  input  logic       x_in,
  input  logic       x_valid,
  output logic       x_ready,
  output logic [3:0] bcd,
  output logic       bcd_valid,
  input  logic       bcd_ready,
  output logic       err
`ifdef EXCESS3_ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  state_e     state_q;
  logic [1:0] bit_cnt_q;
  logic [3:0] sr_q;
  logic [3:0] sr_d;
  logic [3:0] bcd_q;
  logic       err_q;
  logic       bcd_valid_q;

  logic       accept;
  logic       digit_done;
  logic [3:0] dec_bcd;
  logic       dec_err;

  // The 4th bit is stalled only while the output stage is full and not draining.
  assign x_ready    = !(bcd_valid_q && !bcd_ready && bit_cnt_q == LAST_BIT);
  assign accept     = x_valid && x_ready && !sclr;
  assign digit_done = accept && state_q == SHIFT && bit_cnt_q == LAST_BIT;

  // sr_d is the full code once the incoming bit is merged in, so the decoder
  // sees the completed digit on the same edge that accepts its last bit.
  always_comb begin
    sr_d = {x_in, sr_q[3:1]};
    if (MSB_FIRST) begin
      sr_d = {sr_q[2:0], x_in};
    end
  end

  e3_digit_decode u_decode (
    .code_i (sr_d),
    .bcd_o  (dec_bcd),
    .err_o  (dec_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 2'd0;
      sr_q        <= 4'd0;
      bcd_q       <= 4'd0;
      err_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else begin
      if (sclr) begin
        state_q   <= IDLE;
        bit_cnt_q <= 2'd0;
        sr_q      <= 4'd0;
      end else if (accept) begin
        bit_cnt_q <= bit_cnt_q + 2'd1;
        sr_q      <= digit_done ? 4'd0 : sr_d;
        case (state_q)
          IDLE:    state_q <= SHIFT;
          SHIFT:   if (bit_cnt_q == LAST_BIT) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end

      // A completing digit wins over a drain, giving back-to-back digits with no bubble.
      if (digit_done) begin
        bcd_q       <= dec_bcd;
        err_q       <= dec_err;
        bcd_valid_q <= 1'b1;
      end else if (bcd_ready) begin
        bcd_valid_q <= 1'b0;
      end
    end
  end

  assign bcd       = bcd_q;
  assign err       = err_q;
  assign bcd_valid = bcd_valid_q;

`ifdef EXCESS3_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (digit_done && dec_err && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
